// File: rtl/hs32_pkg.sv
// Shared hs32 pipeline types: inter-stage packets, ALU control, flags and opcode codes.
package hs32_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    typedef struct packed {
        logic       neg;   // invert d2 before the operation
        logic       sub;   // carry-in when cen is clear
        logic       cen;   // take carry-in from the C flag
        logic [1:0] opr;
        logic       fwe;   // commit NZCV on accept
    } hs32_aluctl;

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rn;
        logic [15:0] imm;
        logic        we1;
        logic        we2;
        hs32_aluctl  ctl;
    } hs32_s1pkt;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        we1;
        logic        we2;
        logic [3:0]  rd;
        hs32_aluctl  ctl;
    } hs32_s2pkt;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } hs32_flags;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        we1;
        logic        we2;
        logic        valid;
    } hs32_s3pkt;

endpackage

// File: rtl/hs32_alu.sv
// Combinational hs32 ALU: add/and/or/xor with optional operand inversion and carry-in.
module hs32_alu
    import hs32_pkg::*;
(
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  hs32_aluctl  ctl,
    input  hs32_flags   flags,
    output logic [31:0] result,
    output hs32_flags   flags_n
);

    logic [31:0] b;
    logic        cin;
    logic [32:0] sum;

    always_comb begin
        b       = ctl.neg ? ~d2 : d2;
        cin     = ctl.cen ? flags.c : ctl.sub;
        sum     = {1'b0, d1} + {1'b0, b} + {32'd0, cin};
        result  = sum[31:0];
        flags_n = flags;
        // Logic ops keep C and V from the current flags
        case (ctl.opr)
            ALU_ADD: begin
                result    = sum[31:0];
                flags_n.c = sum[32];
                flags_n.v = (d1[31] == b[31]) && (sum[31] != d1[31]);
            end
            ALU_AND: result = d1 & b;
            ALU_OR:  result = d1 | b;
            default: result = d1 ^ b;
        endcase
        flags_n.n = result[31];
        flags_n.z = (result == 32'd0);
    end

endmodule

// File: rtl/hs32_execute.sv
// hs32 pipeline stage 3: ALU, NZCV register and the writeback stage register.
module hs32_execute
    import hs32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  hs32_s2pkt   data_i,
    input  logic        valid_i,
    input  logic        flush_i,
    output logic [3:0]  rd3_o,
    output logic        stl3_o,
    output logic [3:0]  wp_addr_o,
    output logic [31:0] wp_data_o,
    output logic        wp_we_o,
    output logic [3:0]  flags_o
);

    hs32_s3pkt   s3;
    hs32_flags   flags;
    hs32_flags   alu_flags;
    logic [31:0] alu_result;
    logic        accept;

    assign accept = valid_i && !flush_i;

    hs32_alu u_alu (
        .d1      (data_i.d1),
        .d2      (data_i.d2),
        .ctl     (data_i.ctl),
        .flags   (flags),
        .result  (alu_result),
        .flags_n (alu_flags)
    );

    // A bubble clears only the valid bit; the payload is don't-care once invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            s3    <= '0;
            flags <= '0;
        end else begin
            s3.valid <= accept;
            if (accept) begin
                s3.result <= alu_result;
                s3.rd     <= data_i.rd;
                s3.we1    <= data_i.we1;
                s3.we2    <= data_i.we2;
                if (data_i.ctl.fwe)
                    flags <= alu_flags;
            end
        end
    end

    assign rd3_o     = s3.rd;
    assign wp_addr_o = s3.rd;
    assign wp_data_o = s3.result;
    assign wp_we_o   = s3.valid && s3.we1;
    assign stl3_o    = s3.valid && s3.we1;
    assign flags_o   = flags;

endmodule

// File: tb/tb_hs32_execute.sv
// Scoreboard bench for hs32_execute: driver queues expected stage-3 outputs, monitor checks each cycle.
module tb_hs32_execute;
    import hs32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    hs32_s2pkt   data_i;
    logic        valid_i;
    logic        flush_i;
    logic [3:0]  rd3_o;
    logic        stl3_o;
    logic [3:0]  wp_addr_o;
    logic [31:0] wp_data_o;
    logic        wp_we_o;
    logic [3:0]  flags_o;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  flags;
        logic        full;   // also check addr/data when no write is expected
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    hs32_execute dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .rd3_o     (rd3_o),
        .stl3_o    (stl3_o),
        .wp_addr_o (wp_addr_o),
        .wp_data_o (wp_data_o),
        .wp_we_o   (wp_we_o),
        .flags_o   (flags_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked #1 after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wp_we_o === 1'b1) pulses++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".we"},    {31'd0, wp_we_o}, {31'd0, e.we});
                chk({e.name, ".stl3"},  {31'd0, stl3_o},  {31'd0, e.we});
                chk({e.name, ".flags"}, {28'd0, flags_o}, {28'd0, e.flags});
                if (e.we || e.full) begin
                    chk({e.name, ".addr"}, {28'd0, wp_addr_o}, {28'd0, e.addr});
                    chk({e.name, ".rd3"},  {28'd0, rd3_o},     {28'd0, e.addr});
                    chk({e.name, ".data"}, wp_data_o, e.data);
                end
            end else if (wp_we_o !== 1'b0) begin
                chk("unexpected_write", {31'd0, wp_we_o}, 32'd0);
            end
        end
    end

    // ctl packed as {neg, sub, cen, opr[1:0], fwe}
    task automatic step(input string name, input logic rst, input logic v, input logic fl,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] rd,
                        input logic we1, input logic we2, input logic [5:0] ctl,
                        input logic ewe, input logic [3:0] eaddr, input logic [31:0] edata,
                        input logic [3:0] eflags, input logic efull);
        exp_t e;
        @(posedge clk);
        #2;
        reset      = rst;
        valid_i    = v;
        flush_i    = fl;
        data_i.d1  = d1;
        data_i.d2  = d2;
        data_i.rd  = rd;
        data_i.we1 = we1;
        data_i.we2 = we2;
        data_i.ctl = hs32_aluctl'(ctl);
        e.name = name; e.we = ewe; e.addr = eaddr; e.data = edata;
        e.flags = eflags; e.full = efull;
        exp_q.push_back(e);
    endtask

    localparam logic [5:0] C_ADD  = 6'b000_00_1;
    localparam logic [5:0] C_ADC  = 6'b001_00_1;
    localparam logic [5:0] C_ADCN = 6'b001_00_0;
    localparam logic [5:0] C_SUB  = 6'b110_00_1;
    localparam logic [5:0] C_BIC  = 6'b100_01_0;
    localparam logic [5:0] C_ORF  = 6'b000_10_1;
    localparam logic [5:0] C_XORF = 6'b000_11_1;
    localparam logic [5:0] C_ADDN = 6'b000_00_0;

    initial begin
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; data_i = '0;
        //   name        rst v  fl d1            d2            rd   we1 we2 ctl     ewe eaddr edata         eflg     full
        step("reset0",   1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0000, 1);
        step("reset1",   1, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0000, 1);
        step("add_wrap", 0, 1, 0, 32'hFFFFFFFF, 32'h1,        4'd5, 1, 0, C_ADD,  1, 4'd5, 32'h0,        4'b0110, 0);
        step("adc_c1",   0, 1, 0, 32'h2,        32'h3,        4'd6, 1, 0, C_ADC,  1, 4'd6, 32'h6,        4'b0000, 0);
        step("adc_c0",   0, 1, 0, 32'h2,        32'h3,        4'd7, 1, 0, C_ADCN, 1, 4'd7, 32'h5,        4'b0000, 0);
        step("sub_ovf",  0, 1, 0, 32'h80000000, 32'h1,        4'd1, 1, 0, C_SUB,  1, 4'd1, 32'h7FFFFFFF, 4'b0011, 0);
        step("bic",      0, 1, 0, 32'h0000F0F0, 32'h000000F0, 4'd2, 1, 0, C_BIC,  1, 4'd2, 32'h0000F000, 4'b0011, 0);
        step("bubble",   0, 0, 0, 32'h0,        32'h0,        4'd9, 1, 0, C_ADD,  0, 4'd0, 32'h0,        4'b0011, 0);
        step("flush",    0, 1, 1, 32'h0,        32'h0,        4'd9, 1, 0, C_ADD,  0, 4'd0, 32'h0,        4'b0011, 0);
        step("or_keepcv",0, 1, 0, 32'h80000000, 32'h1,        4'd3, 1, 0, C_ORF,  1, 4'd3, 32'h80000001, 4'b1011, 0);
        step("xor_we2",  0, 1, 0, 32'h1234,     32'h1234,     4'd4, 0, 1, C_XORF, 0, 4'd0, 32'h0,        4'b0111, 0);
        step("single",   0, 1, 0, 32'd10,       32'd20,       4'd8, 1, 0, C_ADDN, 1, 4'd8, 32'd30,       4'b0111, 0);
        step("after1",   0, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0111, 0);
        step("after2",   0, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0111, 0);
        step("rst_inst", 1, 1, 0, 32'hFFFFFFFF, 32'h1,        4'd5, 1, 0, C_ADD,  0, 4'd0, 32'h0,        4'b0000, 1);
        step("post_rst", 0, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0000, 1);
        step("post_rs2", 0, 0, 0, 32'h0,        32'h0,        4'd0, 0, 0, C_ADDN, 0, 4'd0, 32'h0,        4'b0000, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'd0);
        // add_wrap, adc_c1, adc_c0, sub_ovf, bic, or_keepcv, single
        chk("write_pulses", pulses, 32'd7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hs32_execute.md
# hs32_execute

Pipeline stage 3 of the hs32 core, directly downstream of the second decode stage. It consumes the stage-2 packet (operands `d1`/`d2`, destination `rd`, write enables, ALU control). It computes the ALU result, maintains the NZCV flags register, and registers the result for regfile writeback one cycle later. It also drives the stage-3 destination/pending signals that decode uses for its read-after-write stall check.

## Interface

Parameters
- none (data width fixed at 32, register index fixed at 4 bits)

Ports
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `data_i`  in  hs32_s2pkt  stage-2 packet: `d1`, `d2`, `we1`, `we2`, `rd`, `ctl`
- `valid_i`  in  1  `data_i` holds a real instruction this cycle; low when decode stalls (bubble)
- `flush_i`  in  1  discard the instruction being accepted this cycle
- `rd3_o`  out  4  destination register of the instruction held in stage 3
- `stl3_o`  out  1  stage 3 holds a pending regfile write to `rd3_o`
- `wp_addr_o`  out  4  regfile write address
- `wp_data_o`  out  32  regfile write data
- `wp_we_o`  out  1  regfile write enable
- `flags_o`  out  4  architectural flags {N,Z,C,V}

## Operation

- ALU (combinational, from `data_i.ctl`):
  - `b = ctl.neg ? ~d2 : d2`
  - `cin = ctl.cen ? C : ctl.sub`
- `ctl.opr` selects the operation:
  - `opr` 0: 33-bit sum `{1'b0,d1} + {1'b0,b} + cin`; result = sum[31:0]; `Cn` = sum[32]; `Vn` = (d1[31] == b[31]) && (sum[31] != d1[31])
  - `opr` 1: `d1 & b` (BIC is AND with `neg`=1)
  - `opr` 2: `d1 | b`
  - `opr` 3: `d1 ^ b`
- Logic ops (`opr` 1–3) leave C and V unchanged. N = result[31]; Z = (result == 0).
- Accept: an instruction is accepted when `valid_i && !flush_i` at a rising edge. On accept:
  - stage register ← {result, `rd`, `we1`}, valid bit ← 1
  - if `ctl.fwe`, flags ← new NZCV
- No accept: valid bit ← 0 and flags hold.
- `we2` is latched but unused in this block (reserved for the memory stage). It never drives `wp_we_o`.
- Outputs from the stage register:
  - `wp_addr_o` = `rd3_o` = stored rd
  - `wp_data_o` = stored result
  - `wp_we_o` = `stl3_o` = valid & stored `we1`
- Stall contract: decode compares its `rm` against `rd3_o` when `stl3_o` is high. The regfile commits `wp_*` at the next edge, after which the operand reads back correctly.
- Back-to-back flag use: a `cen` instruction directly after a `fwe` instruction uses the freshly written C. Flags are registered before the consumer reaches stage 3, so no bypass is needed.

## Timing

- Latency: `data_i` at edge N → `wp_*`/`rd3_o`/`stl3_o` valid after edge N, committed at edge N+1.
- Flags update at the accepting edge; `flags_o` is visible the following cycle.
- Throughput: one instruction per cycle; this block never stalls.
- Reset values: valid 0, so `wp_we_o` = 0 and `stl3_o` = 0. `rd3_o` = 0, `wp_addr_o` = 0, `wp_data_o` = 0, `flags_o` = 4'b0000.
- Reset mid-operation drops the held instruction (no writeback). Reset has priority over accept.
- `flush_i` and `valid_i` high together: bubble inserted, flags untouched.
- `valid_i` low: bubble. The previous result is written exactly once, then `wp_we_o` drops.

## Structure

- Shared types package (with `hs32_s1pkt`/`hs32_s2pkt`/`hs32_aluctl`):
  - add `hs32_flags` (packed N,Z,C,V)
  - add `hs32_s3pkt` (result, rd, we1, we2, valid)
  - add `ALU_ADD/AND/OR/XOR` localparams for `opr` codes
- One combinational sub-module, `hs32_alu`:
  - inputs: `d1`, `d2`, `ctl`, `flags`
  - outputs: result, new flags
- `hs32_execute` holds only the stage register, the flags register and the output muxing.

## Test plan

- ADD: d1=0xFFFF_FFFF, d2=1, neg=0, sub=0, cen=0, opr=0, fwe=1, rd=5, we1=1, valid → next cycle wp_we=1, wp_addr=5, wp_data=0; flags N0 Z1 C1 V0.
- SUB overflow: d1=0x8000_0000, d2=1, neg=1, sub=1 → result 0x7FFF_FFFF; flags N0 Z0 C1 V1.
- Carry chain: ADD 0xFFFF_FFFF+1 (C←1), then next cycle ADC (cen=1) 2+3 → result 6. With C=0 the same ADC gives 5.
- BIC: d1=0xF0F0, d2=0x00F0, neg=1, opr=1, fwe=0 → result 0xF000; flags unchanged from the prior value.
- Bubbles and flush: valid_i low → wp_we=0 the next cycle. valid_i=1 with flush_i=1 and fwe=1 → no writeback, flags unchanged. After one instruction then a bubble, exactly one write pulse occurs.
- Reset: assert `reset` the same edge an instruction with we1=1, fwe=1 arrives → all outputs 0 the next cycle, and no write pulse ever appears for that instruction.
